vc_arbiter: RTL and testbench
=============================

VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, giving the width of the VC and D datapath words.
REQ-002 The block SHALL have parameter DEST_BIT, default 4, giving the bit index in the head word that selects the destination (0 = D0, 1 = D1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port enable, input, 1 bit: arbitration permitted (state-machine active).
REQ-006 The block SHALL have ports empty_fifo_VC0 and empty_fifo_VC1, input, 1 bit each: the VC FIFO is empty.
REQ-007 The block SHALL have ports data_out_VC0 and data_out_VC1, input, DATA_WIDTH each: VC FIFO head word, valid whenever the FIFO is not empty (show-ahead).
REQ-008 The block SHALL have ports almost_full_D0 and almost_full_D1, input, 1 bit each: destination FIFO almost full.
REQ-009 The block SHALL have ports weight_VC0 and weight_VC1, input, 4 bits each: consecutive grants allowed per VC.
REQ-010 The block SHALL have ports pop_VC0_fifo and pop_VC1_fifo, output, 1 bit each: combinational pop strobes.
REQ-011 The block SHALL have ports push_D0 and push_D1, output, 1 bit each: registered push strobes.
REQ-012 The block SHALL have port data_out_D, output, DATA_WIDTH: registered word accompanying push_D0/push_D1.
REQ-013 The block SHALL have port busy, output, 1 bit: high in SERVE_VC0/SERVE_VC1 or while a push is in flight.

Function
REQ-014 The block SHALL compute elig_x = !empty_fifo_VCx && !almost_full_D[data_out_VCx[DEST_BIT]] for x in {0,1}.
REQ-015 The block SHALL implement states IDLE, SERVE_VC0 and SERVE_VC1, plus a 4-bit grant counter cnt.
REQ-016 In IDLE, no pop SHALL be issued; with enable=1, elig_0 SHALL move the block to SERVE_VC0, otherwise elig_1 SHALL move it to SERVE_VC1, otherwise it SHALL stay in IDLE.
REQ-017 In SERVE_VCx with enable=1, the grant SHALL go to VCx if elig_x, else to the other VC if it is eligible, else to nobody.
REQ-018 A grant SHALL assert the granted pop strobe in the same cycle.
REQ-019 On a grant to the current VC, cnt SHALL increment; when cnt+1 reaches the effective weight, the state SHALL switch to the other SERVE state and cnt SHALL clear.
REQ-020 On a grant to the other VC, the state SHALL switch to that VC, cnt SHALL be set to 1, and the weight rule SHALL apply immediately (weight 1 means switching back).
REQ-021 With no grant, the state and cnt SHALL hold.
REQ-022 A weight value of 0 SHALL be treated as 1.
REQ-023 The weight SHALL be sampled at every grant.
REQ-024 With enable=0 in any SERVE state, no pop SHALL be issued, the next state SHALL be IDLE, and cnt SHALL clear.
REQ-025 A pop granted in cycle N SHALL produce, in cycle N+1, push_Dd=1 for the destination d = popped word[DEST_BIT], with data_out_D equal to the popped word.
REQ-026 The other push SHALL be 0 in cycle N+1, and both pushes SHALL be 0 in any cycle following a no-grant cycle.
REQ-027 At most one pop and at most one push SHALL be active per cycle.
REQ-028 data_out_D SHALL hold its last value when no push is active.
REQ-029 A push already in flight SHALL complete even if enable falls, or almost_full rises, in cycle N+1.
REQ-030 The almost-full threshold SHALL absorb this one in-flight word.
REQ-031 A blocked head (destination almost full) SHALL NOT block the other VC; the switch rule of REQ-017 applies.

Reset
REQ-032 While reset=1 (asynchronous assertion, synchronous behaviour on release), state SHALL be IDLE, cnt SHALL be 0, push_D0=push_D1=0, data_out_D=0 and busy=0.
REQ-033 While reset=1, pop_VC0_fifo=pop_VC1_fifo=0 regardless of other inputs.
REQ-034 Reset mid-transfer SHALL discard the in-flight push.
REQ-035 The first cycle after release SHALL be evaluated from IDLE.

Verification
REQ-036 Test 1: weights 2/1, both VCs loaded with 4 words to D0, D0 never almost full, enable=1 -> pop order VC0,VC0,VC1,VC0,VC0,VC1,VC1,VC1; each push_D0 follows its pop by 1 cycle with the matching word.
REQ-037 Test 2: VC0 head 6'b010000 (to D1) with almost_full_D1=1, VC1 head 6'b000001 (to D0) -> VC1 is popped; push_D0=1 with 6'b000001 the next cycle; VC0 waits until almost_full_D1=0.
REQ-038 Test 3: from IDLE with both VCs eligible and enable rising -> SERVE_VC0 first, VC0 popped first.
REQ-039 Test 4: enable dropped the cycle after a pop -> that push still occurs, no further pop, state IDLE, busy low one cycle later.
REQ-040 Test 5: weight_VC0=0, weight_VC1=0, both VCs loaded -> strict alternation VC0,VC1,VC0,...
REQ-041 Test 6: reset asserted the cycle after a pop -> outputs go to 0 immediately, no push, cnt=0; after release the block restarts from IDLE.

Source files
------------

// File: rtl/vc_arbiter.sv
// Two-VC weighted round-robin arbiter feeding two destination FIFOs.
// Pops are combinational grants; the popped word is pushed one cycle later.
module vc_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int DEST_BIT   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  empty_fifo_VC0,
    input  logic                  empty_fifo_VC1,
    input  logic [DATA_WIDTH-1:0] data_out_VC0,
    input  logic [DATA_WIDTH-1:0] data_out_VC1,
    input  logic                  almost_full_D0,
    input  logic                  almost_full_D1,
    input  logic [3:0]            weight_VC0,
    input  logic [3:0]            weight_VC1,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [DATA_WIDTH-1:0] data_out_D,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SERVE_VC0 = 2'd1,
        SERVE_VC1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  push_d0_q, push_d0_d;
    logic                  push_d1_q, push_d1_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic       elig0, elig1;
    logic       gnt0, gnt1;
    logic [3:0] w0_eff, w1_eff;
    logic [4:0] cnt_inc;

    // A head is eligible only if its own destination can take one more word.
    assign elig0  = !empty_fifo_VC0 &&
                    !(data_out_VC0[DEST_BIT] ? almost_full_D1 : almost_full_D0);
    assign elig1  = !empty_fifo_VC1 &&
                    !(data_out_VC1[DEST_BIT] ? almost_full_D1 : almost_full_D0);
    assign w0_eff = (weight_VC0 == 4'd0) ? 4'd1 : weight_VC0;
    assign w1_eff = (weight_VC1 == 4'd0) ? 4'd1 : weight_VC1;
    assign cnt_inc = {1'b0, cnt_q} + 5'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_d0_q <= 1'b0;
            push_d1_q <= 1'b0;
            data_q    <= '0;
        end else begin
            push_d0_q <= push_d0_d;
            push_d1_q <= push_d1_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (enable) begin
            case (state_q)
                SERVE_VC0: begin
                    if (elig0)      gnt0 = 1'b1;
                    else if (elig1) gnt1 = 1'b1;
                end
                SERVE_VC1: begin
                    if (elig1)      gnt1 = 1'b1;
                    else if (elig0) gnt0 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Stealing a grant counts as one grant for the thief, so weight 1 bounces straight back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (enable) begin
                    if (elig0)      state_d = SERVE_VC0;
                    else if (elig1) state_d = SERVE_VC1;
                end
            end
            SERVE_VC0: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (gnt0) begin
                    if (cnt_inc >= {1'b0, w0_eff}) begin
                        state_d = SERVE_VC1;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                    end
                end else if (gnt1) begin
                    if (w1_eff == 4'd1) begin
                        state_d = SERVE_VC0;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = SERVE_VC1;
                        cnt_d   = 4'd1;
                    end
                end
            end
            SERVE_VC1: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (gnt1) begin
                    if (cnt_inc >= {1'b0, w1_eff}) begin
                        state_d = SERVE_VC0;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_inc[3:0];
                    end
                end else if (gnt0) begin
                    if (w0_eff == 4'd1) begin
                        state_d = SERVE_VC1;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = SERVE_VC0;
                        cnt_d   = 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        pop_VC0_fifo = gnt0 && !reset;
        pop_VC1_fifo = gnt1 && !reset;
        push_d0_d    = 1'b0;
        push_d1_d    = 1'b0;
        data_d       = data_q;
        if (gnt0) begin
            data_d    = data_out_VC0;
            push_d0_d = !data_out_VC0[DEST_BIT];
            push_d1_d = data_out_VC0[DEST_BIT];
        end else if (gnt1) begin
            data_d    = data_out_VC1;
            push_d0_d = !data_out_VC1[DEST_BIT];
            push_d1_d = data_out_VC1[DEST_BIT];
        end
    end

    assign push_D0    = push_d0_q;
    assign push_D1    = push_d1_q;
    assign data_out_D = data_q;
    assign busy       = (state_q != IDLE) || push_d0_q || push_d1_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed bench for vc_arbiter: bench-owned VC FIFOs, a grant/streak model
// checked every cycle, and hand-computed pop/push orders for each scenario.
module tb_vc_arbiter;
    localparam int DW   = 6;
    localparam int DEST = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic          empty_fifo_VC0, empty_fifo_VC1;
    logic [DW-1:0] data_out_VC0, data_out_VC1;
    logic          almost_full_D0, almost_full_D1;
    logic [3:0]    weight_VC0, weight_VC1;
    logic          pop_VC0_fifo, pop_VC1_fifo;
    logic          push_D0, push_D1;
    logic [DW-1:0] data_out_D;
    logic          busy;

    vc_arbiter #(.DATA_WIDTH(DW), .DEST_BIT(DEST)) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .empty_fifo_VC0 (empty_fifo_VC0),
        .empty_fifo_VC1 (empty_fifo_VC1),
        .data_out_VC0   (data_out_VC0),
        .data_out_VC1   (data_out_VC1),
        .almost_full_D0 (almost_full_D0),
        .almost_full_D1 (almost_full_D1),
        .weight_VC0     (weight_VC0),
        .weight_VC1     (weight_VC1),
        .pop_VC0_fifo   (pop_VC0_fifo),
        .pop_VC1_fifo   (pop_VC1_fifo),
        .push_D0        (push_D0),
        .push_D1        (push_D1),
        .data_out_D     (data_out_D),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            pop_log[$];
    logic [DW-1:0] push_word_log[$];
    int            push_dest_log[$];

    // Model: which VC is being served (-1 = idle), how many grants in a row it has had,
    // and the word that will appear on the destination side next cycle.
    int            m_serve;
    int            m_streak;
    bit            m_pv;
    int            m_pdest;
    logic [DW-1:0] m_data;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_serve  = -1;
        m_streak = 0;
        m_pv     = 1'b0;
        m_pdest  = 0;
        m_data   = '0;
    endtask

    function automatic int eff_weight(input int vc);
        int w;
        w = (vc == 1) ? int'(weight_VC1) : int'(weight_VC0);
        return (w == 0) ? 1 : w;
    endfunction

    function automatic bit dest_full(input logic d);
        return d ? almost_full_D1 : almost_full_D0;
    endfunction

    // One clock cycle: present FIFO heads, compare against the model, then advance both.
    task automatic apply_stimulus();
        int            g;
        bit            e[2];
        logic [DW-1:0] h[2];
        bit            act0, act1;
        data_out_VC0   = (q0.size() > 0) ? q0[0] : '0;
        data_out_VC1   = (q1.size() > 0) ? q1[0] : '0;
        empty_fifo_VC0 = (q0.size() == 0);
        empty_fifo_VC1 = (q1.size() == 0);
        #1;
        if (reset) model_reset();
        h[0] = data_out_VC0;
        h[1] = data_out_VC1;
        e[0] = (q0.size() > 0) && !dest_full(h[0][DEST]);
        e[1] = (q1.size() > 0) && !dest_full(h[1][DEST]);
        g = -1;
        if (!reset && enable && m_serve >= 0) begin
            if (e[m_serve])          g = m_serve;
            else if (e[1 - m_serve]) g = 1 - m_serve;
        end
        check_output("pop_VC0", 32'(pop_VC0_fifo), 32'(g == 0));
        check_output("pop_VC1", 32'(pop_VC1_fifo), 32'(g == 1));
        check_output("push_D0", 32'(push_D0), 32'(m_pv && m_pdest == 0));
        check_output("push_D1", 32'(push_D1), 32'(m_pv && m_pdest == 1));
        check_output("data_out_D", 32'(data_out_D), 32'(m_data));
        check_output("busy", 32'(busy), 32'(m_serve >= 0 || m_pv));
        if (push_D0) begin push_word_log.push_back(data_out_D); push_dest_log.push_back(0); end
        if (push_D1) begin push_word_log.push_back(data_out_D); push_dest_log.push_back(1); end
        act0 = pop_VC0_fifo;
        act1 = pop_VC1_fifo;
        @(posedge clk);
        if (act0) begin pop_log.push_back(0); if (q0.size() > 0) void'(q0.pop_front()); end
        if (act1) begin pop_log.push_back(1); if (q1.size() > 0) void'(q1.pop_front()); end
        if (reset) begin
            model_reset();
        end else begin
            m_pv = (g >= 0);
            if (g >= 0) begin
                m_pdest = int'(h[g][DEST]);
                m_data  = h[g];
            end
            if (m_serve < 0) begin
                m_streak = 0;
                if (enable) begin
                    if (e[0])      m_serve = 0;
                    else if (e[1]) m_serve = 1;
                end
            end else if (!enable) begin
                m_serve  = -1;
                m_streak = 0;
            end else if (g >= 0) begin
                if (g == m_serve) begin
                    m_streak++;
                end else begin
                    m_serve  = g;
                    m_streak = 1;
                end
                if (m_streak >= eff_weight(g)) begin
                    m_serve  = 1 - g;
                    m_streak = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) apply_stimulus();
    endtask

    task automatic restart(input logic [3:0] w0, input logic [3:0] w1);
        reset = 1'b1;
        enable = 1'b0;
        almost_full_D0 = 1'b0;
        almost_full_D1 = 1'b0;
        weight_VC0 = w0;
        weight_VC1 = w1;
        q0.delete();
        q1.delete();
        run(2);
        pop_log.delete();
        push_word_log.delete();
        push_dest_log.delete();
        reset = 1'b0;
    endtask

    initial begin
        int exp_pop1[8];
        logic [DW-1:0] exp_push1[8];
        int exp_pop5[6];
        model_reset();
        reset = 1'b1;
        enable = 1'b1;
        almost_full_D0 = 1'b0;
        almost_full_D1 = 1'b0;
        weight_VC0 = 4'd1;
        weight_VC1 = 4'd1;
        q0 = '{6'd7};
        q1 = '{6'd9};
        @(negedge clk);
        run(2);
        check_output("reset_pop_count", 32'(pop_log.size()), 32'd0);
        check_output("reset_busy", 32'(busy), 32'd0);

        $display("[TB] test 1: weights 2/1, both VCs to D0");
        restart(4'd2, 4'd1);
        q0 = '{6'd1, 6'd2, 6'd3, 6'd4};
        q1 = '{6'd8, 6'd9, 6'd10, 6'd11};
        enable = 1'b1;
        run(12);
        exp_pop1  = '{0, 0, 1, 0, 0, 1, 1, 1};
        exp_push1 = '{6'd1, 6'd2, 6'd8, 6'd3, 6'd4, 6'd9, 6'd10, 6'd11};
        check_output("t1_pop_count", 32'(pop_log.size()), 32'd8);
        check_output("t1_push_count", 32'(push_word_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < pop_log.size()) check_output($sformatf("t1_pop%0d", i), 32'(pop_log[i]), 32'(exp_pop1[i]));
            if (i < push_word_log.size()) begin
                check_output($sformatf("t1_word%0d", i), 32'(push_word_log[i]), 32'(exp_push1[i]));
                check_output($sformatf("t1_dest%0d", i), 32'(push_dest_log[i]), 32'd0);
            end
        end

        $display("[TB] test 2: blocked VC0 head does not block VC1");
        restart(4'd1, 4'd1);
        q0 = '{6'b010000};
        q1 = '{6'b000001};
        almost_full_D1 = 1'b1;
        enable = 1'b1;
        run(5);
        check_output("t2_pop_count", 32'(pop_log.size()), 32'd1);
        if (pop_log.size() > 0) check_output("t2_first_pop", 32'(pop_log[0]), 32'd1);
        check_output("t2_push_count", 32'(push_word_log.size()), 32'd1);
        if (push_word_log.size() > 0) begin
            check_output("t2_word0", 32'(push_word_log[0]), 32'd1);
            check_output("t2_dest0", 32'(push_dest_log[0]), 32'd0);
        end
        almost_full_D1 = 1'b0;
        run(4);
        check_output("t2_pop_count_b", 32'(pop_log.size()), 32'd2);
        if (pop_log.size() > 1) check_output("t2_second_pop", 32'(pop_log[1]), 32'd0);
        if (push_word_log.size() > 1) begin
            check_output("t2_word1", 32'(push_word_log[1]), 32'b010000);
            check_output("t2_dest1", 32'(push_dest_log[1]), 32'd1);
        end

        $display("[TB] test 3: enable rising with both eligible");
        restart(4'd1, 4'd1);
        q0 = '{6'd2};
        q1 = '{6'd3};
        run(2);
        check_output("t3_no_pop_disabled", 32'(pop_log.size()), 32'd0);
        enable = 1'b1;
        run(4);
        check_output("t3_pop_count", 32'(pop_log.size()), 32'd2);
        if (pop_log.size() > 0) check_output("t3_first_pop", 32'(pop_log[0]), 32'd0);

        $display("[TB] test 4: enable dropped after a pop");
        restart(4'd3, 4'd3);
        q0 = '{6'd1, 6'd2, 6'd3};
        enable = 1'b1;
        run(2);
        enable = 1'b0;
        run(1);
        check_output("t4_push_count", 32'(push_word_log.size()), 32'd1);
        run(1);
        check_output("t4_busy_low", 32'(busy), 32'd0);
        run(2);
        check_output("t4_pop_count", 32'(pop_log.size()), 32'd1);

        $display("[TB] test 5: zero weights alternate");
        restart(4'd0, 4'd0);
        q0 = '{6'd1, 6'd2, 6'd3};
        q1 = '{6'd8, 6'd9, 6'd10};
        enable = 1'b1;
        run(9);
        exp_pop5 = '{0, 1, 0, 1, 0, 1};
        check_output("t5_pop_count", 32'(pop_log.size()), 32'd6);
        for (int i = 0; i < 6; i++)
            if (i < pop_log.size()) check_output($sformatf("t5_pop%0d", i), 32'(pop_log[i]), 32'(exp_pop5[i]));

        $display("[TB] test 6: reset the cycle after a pop");
        restart(4'd3, 4'd3);
        q0 = '{6'd5, 6'd6};
        enable = 1'b1;
        run(2);
        reset = 1'b1;
        #1;
        check_output("t6_push_D0_now", 32'(push_D0), 32'd0);
        check_output("t6_data_now", 32'(data_out_D), 32'd0);
        check_output("t6_busy_now", 32'(busy), 32'd0);
        run(2);
        reset = 1'b0;
        run(1);
        check_output("t6_idle_after_release", 32'(pop_log.size()), 32'd1);
        run(2);
        check_output("t6_push_discarded", 32'(push_word_log.size()), 32'd1);
        if (push_word_log.size() > 0) check_output("t6_restart_word", 32'(push_word_log[0]), 32'd6);
        check_output("t6_pop_count", 32'(pop_log.size()), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
